lock_sequencer: RTL
===================

# lock_sequencer

Code-entry controller for the digital lock. Conditions the five raw push-buttons `d1`–`d5`, collects a fixed-length digit sequence, and compares it against a parameterised code. It sequences the lock/unlock outputs, counts failed attempts and enforces an optional lockout period. It sits between the board buttons and the lock output/display stage, and its status outputs feed the seven-segment driver.

## Interface
- `CODE_LEN`, 3 — digits per attempt, 1..7.
- `CODE`, {3'd2,3'd3,3'd1} — expected code, 3 bits per digit, first digit in the MS field; digit values 1..5.
- `DEBOUNCE_CYCLES`, 500 — consecutive stable samples needed to accept a button level.
- `ENTRY_TIMEOUT`, 20000 — idle cycles in ENTRY before the partial entry is discarded.
- `UNLOCK_CYCLES`, 5000 — duration of the OPEN state.
- `MAX_FAILS`, 3 — consecutive failed attempts that trigger lockout, 1..7.
- `LOCKOUT_CYCLES`, 50000 — duration of the LOCKOUT state.

Ports:
- `clk` in 1 — single clock, rising edge.
- `reset` in 1 — synchronous, active-high.
- `d1`..`d5` in 1 each — raw asynchronous buttons, high = pressed; two-flop synchronised internally.
- `unlock` out 1 — high only in OPEN.
- `lock` out 1 — inverse of `unlock`.
- `lockout` out 1 — high only in LOCKOUT.
- `digit_count` out 3 — digits captured in the current attempt.
- `last_digit` out 3 — value 1..5 of the most recent accepted press; 0 if none.
- `fail_count` out 3 — consecutive failed attempts.

## Operation
- **Debounce:** one counter per button, after the synchroniser. The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples differ from it.
- **Press event:** one-cycle pulse on the rising edge of a debounced level. Releases generate no event.
- **Multiple events in one cycle:** accepted as one digit with value 0, which never matches the code.
- **States:** LOCKED, ENTRY, CHECK, OPEN, LOCKOUT. Reset enters LOCKED.
- **LOCKED:**
  - On an event: store the digit, set `digit_count`=1, go to ENTRY.
  - If `CODE_LEN`=1: go straight to CHECK instead.
- **ENTRY:**
  - Each event stores the digit, increments `digit_count` and restarts the timeout counter.
  - When `digit_count` reaches `CODE_LEN`, go to CHECK.
  - After `ENTRY_TIMEOUT` cycles without an event: clear `digit_count`, go to LOCKED. `fail_count` is unchanged.
- **CHECK (one cycle):** all stored digits are compared at once; there is no early abort.
  - Match: clear `fail_count`, go to OPEN.
  - Mismatch: increment `fail_count` (saturating at 7).
    - If the new value is ≥ `MAX_FAILS` and lockout is compiled in: go to LOCKOUT.
    - Otherwise: go to LOCKED.
  - `digit_count` clears on exit.
- **OPEN:** events are ignored. After `UNLOCK_CYCLES` cycles, go to LOCKED.
- **LOCKOUT:** events are ignored. After `LOCKOUT_CYCLES` cycles, clear `fail_count` and go to LOCKED.
- **Held button:** a press still held on entry to LOCKED produces no event. A new rising edge is required.
- **Reset mid-operation:** aborts any state. All counters, stored digits, the debounced levels (to 0) and the synchronisers are cleared.

## Timing
- **Reset values:** `unlock`=0, `lock`=1, `lockout`=0, `digit_count`=0, `last_digit`=0, `fail_count`=0.
- **Raw edge to `digit_count`/`last_digit` update:** 2 sync + `DEBOUNCE_CYCLES` + 1 (event register) + 1 (state register). This is 504 cycles at the defaults.
- **Final event to result:**
  - The final-digit event at edge E moves the FSM to CHECK at E+1.
  - On a match, `unlock` rises at E+2.
  - On a mismatch, `fail_count` and `lockout` update at E+2.
- **OPEN duration:** `unlock` stays high for exactly `UNLOCK_CYCLES` cycles.
- **LOCKOUT duration:** `lockout` stays high for exactly `LOCKOUT_CYCLES` cycles.
- **Outputs:** all registered; no combinational path from `d1`..`d5` to any output.

## Configuration
- **`LOCK_LOCKOUT_EN` defined:** the LOCKOUT state, its counter and the `MAX_FAILS` check are built.
- **`LOCK_LOCKOUT_EN` undefined:**
  - LOCKOUT is absent and `lockout` is tied to 0.
  - A mismatch always returns to LOCKED.
  - `fail_count` still counts, saturates at 7 and clears on a match.

## Test plan
- **Correct code:** press/release d2, d3, d1, each held 1000 cycles with 1000 cycles between. Required: `digit_count` 1→2→3, `last_digit` 2,3,1, `unlock`=1 for 5000 cycles then `lock`=1, `fail_count`=0.
- **Wrong code:** enter d2, d4, d1. Required: no unlock, `fail_count`=1, back in LOCKED. A following correct 2-3-1 unlocks and clears `fail_count` to 0.
- **Lockout (macro defined):** three wrong codes. Required: `lockout`=1 for 50000 cycles with presses ignored, then `fail_count`=0. Repeat without the macro: no lockout, `fail_count`=3.
- **Bounce rejection:** d3 high for 300 cycles, low, high for 1000. Required: exactly one event, `digit_count`=1, `last_digit`=3.
- **Simultaneous presses:** d1 and d2 rise together as digit 1, then d3, d1 entered. Required: mismatch, `fail_count`=1.
- **Reset and timeout:** reset after 2 digits. Required: all outputs return to their reset values the next cycle. Separately, enter 1 digit then idle for 20000 cycles. Required: `digit_count`=0, `fail_count` unchanged.

Source files
------------

// File: rtl/lock_sequencer.sv
// Button-driven code lock: debounce, digit capture, compare, open/lockout timing.
// Optional LOCK_LOCKOUT_EN builds the lockout state after MAX_FAILS misses.
module lock_sequencer #(
  parameter int CODE_LEN = 3,
  parameter logic [3*CODE_LEN-1:0] CODE = {3'd2, 3'd3, 3'd1},
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int ENTRY_TIMEOUT = 20000,
  parameter int UNLOCK_CYCLES = 5000,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  input  logic       d4,
  input  logic       d5,
  output logic       unlock,
  output logic       lock,
  output logic       lockout,
  output logic [2:0] digit_count,
  output logic [2:0] last_digit,
  output logic [2:0] fail_count
);

  localparam int W = 3 * CODE_LEN;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TM1 = (ENTRY_TIMEOUT > UNLOCK_CYCLES) ?
                       ENTRY_TIMEOUT : UNLOCK_CYCLES;
  localparam int TMAX = (TM1 > LOCKOUT_CYCLES) ? TM1 : LOCKOUT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0] CL = 3'(CODE_LEN);
  localparam logic [2:0] MF = 3'(MAX_FAILS);

  typedef enum logic [2:0] {
    LOCKED, ENTRY, CHECK, OPEN, LOCKOUT
  } state_t;

  logic [4:0]    raw, s1, s2, deb, deb_q, ev;
  logic [DW-1:0] dcnt [5];
  logic          hit, multi;
  logic [2:0]    val, fc_inc;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    dc, dc_n, ld, ld_n, fc, fc_n;
  logic [W-1:0]  digits, digits_n;

  assign raw = {d5, d4, d3, d2, d1};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= '0;
      s2    <= '0;
      deb   <= '0;
      deb_q <= '0;
      ev    <= '0;
      for (int i = 0; i < 5; i++) dcnt[i] <= '0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      deb_q <= deb;
      ev    <= deb & ~deb_q;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DLAST) begin
          deb[i]  <= s2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // Two or more buttons in one cycle collapse to digit 0.
  always_comb begin
    hit   = |ev;
    multi = |(ev & (ev - 5'd1));
    val   = 3'd0;
    if (!multi) begin
      unique case (1'b1)
        ev[0]:   val = 3'd1;
        ev[1]:   val = 3'd2;
        ev[2]:   val = 3'd3;
        ev[3]:   val = 3'd4;
        ev[4]:   val = 3'd5;
        default: val = 3'd0;
      endcase
    end
  end

  assign fc_inc = (fc == 3'd7) ? 3'd7 : fc + 3'd1;

  always_comb begin
    state_n  = state;
    timer_n  = timer;
    dc_n     = dc;
    ld_n     = ld;
    fc_n     = fc;
    digits_n = digits;
    unique case (state)
      LOCKED: begin
        if (hit) begin
          digits_n = (digits << 3) | W'(val);
          ld_n     = val;
          dc_n     = 3'd1;
          timer_n  = '0;
          state_n  = (CL == 3'd1) ? CHECK : ENTRY;
        end
      end
      ENTRY: begin
        if (hit) begin
          digits_n = (digits << 3) | W'(val);
          ld_n     = val;
          dc_n     = dc + 3'd1;
          timer_n  = '0;
          if (dc + 3'd1 == CL) state_n = CHECK;
        end else if (timer == TW'(ENTRY_TIMEOUT - 1)) begin
          dc_n    = 3'd0;
          state_n = LOCKED;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      CHECK: begin
        dc_n    = 3'd0;
        timer_n = '0;
        if (digits == CODE) begin
          fc_n    = 3'd0;
          state_n = OPEN;
        end else begin
          fc_n    = fc_inc;
          state_n = LOCKED;
`ifdef LOCK_LOCKOUT_EN
          if (fc_inc >= MF) state_n = LOCKOUT;
`endif
        end
      end
      OPEN: begin
        if (timer == TW'(UNLOCK_CYCLES - 1)) begin
          timer_n = '0;
          state_n = LOCKED;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
`ifdef LOCK_LOCKOUT_EN
      LOCKOUT: begin
        if (timer == TW'(LOCKOUT_CYCLES - 1)) begin
          timer_n = '0;
          fc_n    = 3'd0;
          state_n = LOCKED;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
`endif
      default: state_n = LOCKED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= LOCKED;
      timer   <= '0;
      dc      <= '0;
      ld      <= '0;
      fc      <= '0;
      digits  <= '0;
      unlock  <= 1'b0;
      lock    <= 1'b1;
      lockout <= 1'b0;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      dc      <= dc_n;
      ld      <= ld_n;
      fc      <= fc_n;
      digits  <= digits_n;
      unlock  <= (state_n == OPEN);
      lock    <= (state_n != OPEN);
`ifdef LOCK_LOCKOUT_EN
      lockout <= (state_n == LOCKOUT);
`else
      lockout <= 1'b0;
`endif
    end
  end

`ifndef LOCK_LOCKOUT_EN
  logic unused_mf;
  assign unused_mf = ^MF;
`endif

  assign digit_count = dc;
  assign last_digit  = ld;
  assign fail_count  = fc;

endmodule
